// File: rtl/shift_reg_univ_if.sv
// Bus bundle for shift_reg_univ: control, serial/parallel data in, stage contents out.
// No valid/ready handshake here: every rising clk with en=1 is a transfer of the
// selected mode, and en=0 stalls the register completely.
interface shift_reg_univ_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 6
);
    localparam int FW = $clog2(DEPTH + 1);

    logic                   en;
    logic [2:0]             mode;
    logic [WIDTH-1:0]       sin_lo;
    logic [WIDTH-1:0]       sin_hi;
    logic [WIDTH*DEPTH-1:0] pdata;
    logic [WIDTH*DEPTH-1:0] taps;
    logic [WIDTH-1:0]       sout_hi;
    logic [WIDTH-1:0]       sout_lo;
    logic [FW-1:0]          fill;
    logic                   full;

    modport master (
        output en, mode, sin_lo, sin_hi, pdata,
        input  taps, sout_hi, sout_lo, fill, full
    );

    modport slave (
        input  en, mode, sin_lo, sin_hi, pdata,
        output taps, sout_hi, sout_lo, fill, full
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold, serial shift
// up/down, rotate, parallel load and clear, plus a saturating fill count.
// All outputs come straight from registered state.
module shift_reg_univ #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 6
) (
    input logic           clk,
    input logic           reset,
    shift_reg_univ_if.slave bus
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    typedef enum logic [2:0] {
        M_HOLD   = 3'd0,
        M_SHL_UP = 3'd1,
        M_SHR_DN = 3'd2,
        M_LOAD   = 3'd3,
        M_ROT_UP = 3'd4,
        M_ROT_DN = 3'd5,
        M_CLEAR  = 3'd6,
        M_RSVD   = 3'd7
    } mode_e;

    logic [WIDTH-1:0]       stage_q [DEPTH];
    logic [WIDTH-1:0]       stage_d [DEPTH];
    logic [FW-1:0]          fill_q;
    logic [FW-1:0]          fill_d;
    logic [FW-1:0]          fill_inc;
    logic [WIDTH*DEPTH-1:0] taps_w;

    // Shifts bump the count by one regardless of direction, saturating at DEPTH.
    assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);

    // Next-state selection; en=0 and the reserved code fall through to hold.
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (bus.en) begin
            case (mode_e'(bus.mode))
                M_SHL_UP: begin
                    stage_d[0] = bus.sin_lo;
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                    fill_d = fill_inc;
                end
                M_SHR_DN: begin
                    stage_d[DEPTH-1] = bus.sin_hi;
                    for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
                    fill_d = fill_inc;
                end
                M_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) stage_d[i] = bus.pdata[i*WIDTH +: WIDTH];
                    fill_d = FILL_MAX;
                end
                M_ROT_UP: begin
                    stage_d[0] = stage_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
                end
                M_ROT_DN: begin
                    stage_d[DEPTH-1] = stage_q[0];
                    for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
                end
                M_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
                    fill_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // State register; synchronous active-low reset discards everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            fill_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
            fill_q <= fill_d;
        end
    end

    // Pack stages into the flat taps bus, stage i at bits [i*WIDTH +: WIDTH].
    always_comb begin
        taps_w = '0;
        for (int i = 0; i < DEPTH; i++) taps_w[i*WIDTH +: WIDTH] = stage_q[i];
    end

    assign bus.taps    = taps_w;
    assign bus.sout_hi = stage_q[DEPTH-1];
    assign bus.sout_lo = stage_q[0];
    assign bus.fill    = fill_q;
    assign bus.full    = (fill_q == FILL_MAX);
endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: DEPTH stages of WIDTH bits each. It supports hold, bidirectional serial shift, rotate, parallel load and clear, and tracks how many stages hold valid shifted-in or loaded data. It is the general-purpose successor to the fixed 1-bit serial-in/serial-out D-flip-flop chain, and is used for serial/parallel conversion, delay lines and ring buffers in lab designs.

## Interface
- WIDTH, 1, bits per stage (≥1)
- DEPTH, 6, number of stages (≥2)
- FW, $clog2(DEPTH+1), width of fill count (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- en  in  1  clock enable; 0 forces hold
- mode  in  3  operation select (see Operation)
- sin_lo  in  WIDTH  serial input into stage 0 (shift-up)
- sin_hi  in  WIDTH  serial input into stage DEPTH-1 (shift-down)
- pdata  in  WIDTH*DEPTH  parallel load data; stage i = pdata[i*WIDTH +: WIDTH]
- taps  out  WIDTH*DEPTH  all stage contents, same packing as pdata
- sout_hi  out  WIDTH  stage DEPTH-1 contents
- sout_lo  out  WIDTH  stage 0 contents
- fill  out  FW  count of valid stages, 0..DEPTH
- full  out  1  fill == DEPTH

## Operation
- Storage: stage[0..DEPTH-1]. All outputs are registered state or direct decodes of registered state, with no combinational path from inputs.
- Priority on each rising clk: reset==0, then en==0 (hold everything), then mode.
- Modes:
  - 000 HOLD: no change.
  - 001 SHL_UP: stage[0]<=sin_lo; stage[i]<=stage[i-1]; fill<=min(fill+1,DEPTH).
  - 010 SHR_DN: stage[DEPTH-1]<=sin_hi; stage[i]<=stage[i+1]; fill<=min(fill+1,DEPTH).
  - 011 LOAD: stage[i]<=pdata slice i; fill<=DEPTH.
  - 100 ROT_UP: stage[0]<=stage[DEPTH-1]; stage[i]<=stage[i-1]; fill unchanged.
  - 101 ROT_DN: stage[DEPTH-1]<=stage[0]; stage[i]<=stage[i+1]; fill unchanged.
  - 110 CLEAR: all stages<=0; fill<=0.
  - 111 reserved: behaves as HOLD.
- fill saturates at DEPTH and never wraps. The shift direction does not affect the count; a mix of up and down shifts counts as one fill increment per shift.
- sin_lo and sin_hi are ignored in every mode except their own shift mode. pdata is ignored except in LOAD.

## Timing
- Reset (reset==0 at a rising edge): all stages 0, taps=0, sout_hi=0, sout_lo=0, fill=0, full=0 after that edge. Reset overrides en and mode.
- Reset asserted mid-stream discards all contents on that edge. The first post-reset shift produces fill=1.
- Single-cycle update: the effect of mode is visible on the outputs immediately after the sampling edge.
- Serial latency: a word on sin_lo under continuous SHL_UP appears on sout_hi after DEPTH edges. SHR_DN is symmetric, from sin_hi to sout_lo.
- Serial-to-parallel: DEPTH consecutive SHL_UP cycles from empty produce full=1 on the same edge as the DEPTH-th shift.
- Parallel-to-serial: LOAD then DEPTH-1 SHL_UP shifts drains stage 0 content to sout_hi. The load value of stage DEPTH-1 is on sout_hi right after the LOAD edge.
- en low for any number of cycles freezes all state, including fill. Resuming continues exactly where it stopped.

## Test plan
- WIDTH=1, DEPTH=6, reset low 2 cycles, then SHL_UP with sin_lo=1 for one cycle, then 0 → sout_hi=1 exactly on the 6th edge after the 1 was sampled, 0 otherwise. fill steps 1..6, full rises with the 6th shift.
- WIDTH=4, DEPTH=4, LOAD pdata=16'hA5C3 → taps=16'hA5C3, sout_lo=4'h3, sout_hi=4'hA, fill=4. Then ROT_UP ×1 → taps=16'h5C3A. Then ROT_DN ×1 → taps=16'hA5C3, fill stays 4.
- WIDTH=4, DEPTH=4, CLEAR then SHR_DN with sin_hi=1,2,3,4 → taps=16'h4321, full=1. A 5th shift with sin_hi=5 gives taps=16'h5432, fill stays 4.
- en=0 with mode=LOAD and mode=CLEAR held for 3 cycles after taps=16'h1234 → taps, fill and full unchanged. Mode 111 with en=1 → also unchanged.
- Reset low during continuous SHL_UP at fill=3 → next cycle taps=0, fill=0, full=0. Shifting resumes from empty once reset is high.
- Mixed sequence, DEPTH=6: 2× SHL_UP, 1× SHR_DN, 1× CLEAR, 1× SHL_UP → fill reads 1,2,3,0,1 after the respective edges.
